imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the fetch stage (read-only) and the data-memory stage (read/write).
- Grants at most one access per cycle and translates byte addresses from the text and data segments into word indices.
- Returns read data one cycle after grant.
- Sits between the pipeline's IF/MEM stages and the memory array; a deasserted gnt is the stall source for the requesting stage.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width of both requesters
- MEM_AW, 10, word-index width; memory depth = 2**MEM_AW
- TEXT_BASE, 32'h0040_0000, byte address of word 0 of the text segment
- DATA_BASE, 32'h1001_0000, byte address of the first data-segment word
- DATA_OFS, 512, word index where the data segment begins inside the memory
- MAX_STARVE, 3, consecutive fetch losses before fetch is forced to win

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- if_err  out  1  fetch address fault, qualified by if_rvalid
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_WIDTH  data byte address
- dm_wdata  in  DATA_WIDTH  write data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  data read data valid (reads only)
- dm_rdata  out  DATA_WIDTH  data read data
- dm_err  out  1  data address fault, pulses 1 cycle after a faulting grant (reads and writes)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  MEM_AW  memory word index
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Connection: rst is synchronous and active-high. While rst=1, every output is forced to 0, starve_cnt=0 and the response tracker is NONE.
- Handshake: a requester holds req, addr, we and wdata stable until it sees gnt. gnt is combinational in the same cycle; an access completes in the cycle it is granted.
- Arbitration (the only requester present always wins):
  - both requests and starve_cnt<MAX_STARVE: dm wins;
  - both requests and starve_cnt==MAX_STARVE: if wins.
- starve_cnt:
  - +1 when if_req=1 and if_gnt=0, saturating at MAX_STARVE;
  - cleared when if_gnt=1 or if_req=0.
- Fetch address map: index = (if_addr-TEXT_BASE)>>2.
  - Fault if if_addr<TEXT_BASE, or if_addr[1:0]!=0, or index>=DATA_OFS.
- Data address map: index = DATA_OFS+((dm_addr-DATA_BASE)>>2).
  - Fault if dm_addr<DATA_BASE, or dm_addr[1:0]!=0, or index>=2**MEM_AW.
  - All subtraction is done at ADDR_WIDTH, then truncated to MEM_AW.
- Granted, non-faulting access: mem_en=1 and mem_addr=index in the same cycle. mem_we=dm_we and mem_wdata=dm_wdata for data accesses; mem_we=0 for fetches.
- Granted, faulting access: mem_en=0, so writes are dropped. The next cycle pulses rvalid (reads) with rdata=0 and err=1; a faulting write pulses dm_err only.
- Response tracker: a register {src∈NONE/IF/DM, err} loaded on grant.
  - Next cycle, the selected port's rvalid=1 and rdata=mem_rdata (or 0 on err); the other port's rdata=0.
  - A data write loads NONE plus err.
- Back-to-back grants every cycle are supported; responses pipeline one cycle behind grants.
- Reset mid-operation: a response tracked from the cycle before rst is discarded; no rvalid follows reset.
- No request: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

Test Plan:
- rst=1 for 2 cycles with if_req=dm_req=1 -> all outputs 0. After release, dm wins first cycle.
- if_req only, if_addr=0x0040_0008, memory word 2=0x2002_0005 -> if_gnt same cycle, mem_addr=2, next cycle if_rvalid=1, if_rdata=0x2002_0005, if_err=0.
- dm write 0x1001_0004 data 0xDEAD_BEEF, then dm read same address -> first cycle mem_we=1, mem_addr=513; read returns 0xDEAD_BEEF one cycle after its grant, dm_rvalid=0 after the write.
- if_req and dm_req held continuously for 8 cycles -> grant pattern dm,dm,dm,if,dm,dm,dm,if; starve_cnt resets to 0 after each fetch win.
- if_addr=0x0040_0002 (misaligned) and dm read at 0x0FFF_FFFC (below base) -> mem_en=0 on each grant, next cycle rvalid=1, rdata=0, err=1. A dm write to 0x1001_0802 gives dm_err=1, mem_we=0.
- dm read granted, rst asserted the following cycle -> dm_rvalid stays 0 and the tracker is NONE after reset.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one single-port unified memory between instruction fetch (read
//   only) and the data-memory stage (read/write). At most one access is
//   granted per cycle. Read data returns one cycle after the grant.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req/if_addr      fetch request and byte address
//   if_gnt              fetch accepted this cycle (combinational)
//   if_rvalid/rdata/err fetch response, one cycle after grant
//   dm_req/we/addr/wdata data request
//   dm_gnt              data request accepted this cycle (combinational)
//   dm_rvalid/rdata     data read response, one cycle after grant
//   dm_err              data address fault, one cycle after grant (rd and wr)
//   mem_en/we/addr/wdata memory strobe, word index, write data
//   mem_rdata           memory read data, one cycle after mem_en
module imem_dmem_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_AW     = 10,
  parameter logic [ADDR_WIDTH-1:0] TEXT_BASE  = 'h0040_0000,
  parameter logic [ADDR_WIDTH-1:0] DATA_BASE  = 'h1001_0000,
  parameter int                    DATA_OFS   = 512,
  parameter int                    MAX_STARVE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0]         STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [ADDR_WIDTH-1:0] OFS_W      = ADDR_WIDTH'(DATA_OFS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W    = ADDR_WIDTH'(2 ** MEM_AW);

  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_IF = 2'd1, SRC_DM = 2'd2} src_e;

  // Response tracker: which port owns next cycle's response, and whether it faulted.
  typedef struct packed {
    src_e src;
    logic err;
  } resp_t;

  resp_t         resp_q, resp_d;
  logic [SW-1:0] starve_cnt;

  // Address translation is done at full address width so an out-of-range
  // offset cannot alias into the memory after truncation.
  logic [ADDR_WIDTH-1:0] if_off, if_idx, dm_off, dm_idx;
  logic                  if_fault, dm_fault, dm_win;

  always_comb begin
    if_off   = if_addr - TEXT_BASE;
    if_idx   = if_off >> 2;
    if_fault = (if_addr < TEXT_BASE) || (if_addr[1:0] != 2'b00) || (if_idx >= OFS_W);
    dm_off   = dm_addr - DATA_BASE;
    dm_idx   = OFS_W + (dm_off >> 2);
    dm_fault = (dm_addr < DATA_BASE) || (dm_addr[1:0] != 2'b00) || (dm_idx >= DEPTH_W);
  end

  // Data side has priority until fetch has lost MAX_STARVE times in a row.
  assign dm_win = dm_req && (!if_req || (starve_cnt < STARVE_MAX));
  assign dm_gnt = !rst && dm_win;
  assign if_gnt = !rst && if_req && !dm_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt && !dm_fault) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_idx[MEM_AW-1:0];
      mem_wdata = dm_wdata;
    end else if (if_gnt && !if_fault) begin
      mem_en   = 1'b1;
      mem_addr = if_idx[MEM_AW-1:0];
    end
  end

  // Writes never produce read data, but still carry their fault bit so
  // dm_err can pulse.
  always_comb begin
    resp_d = '{src: SRC_NONE, err: 1'b0};
    if (if_gnt)      resp_d = '{src: SRC_IF, err: if_fault};
    else if (dm_gnt) resp_d = '{src: (dm_we ? SRC_NONE : SRC_DM), err: dm_fault};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q     <= '{src: SRC_NONE, err: 1'b0};
      starve_cnt <= '0;
    end else begin
      resp_q <= resp_d;
      if (if_req && !if_gnt)
        starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
    end
  end

  always_comb begin
    if_rvalid = !rst && (resp_q.src == SRC_IF);
    dm_rvalid = !rst && (resp_q.src == SRC_DM);
    if_err    = if_rvalid && resp_q.err;
    dm_err    = !rst && resp_q.err && (resp_q.src != SRC_IF);
    if_rdata  = (if_rvalid && !resp_q.err) ? mem_rdata : '0;
    dm_rdata  = (dm_rvalid && !resp_q.err) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench: a reference model computes grants, memory strobes and
// the response each grant will produce; responses are queued and compared
// one cycle later against the DUT.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Physical memory driven by the DUT.
  logic [31:0] phys [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) phys[mem_addr] <= mem_wdata;
      else        mem_rdata      <= phys[mem_addr];
    end
  end

  typedef struct {
    bit          iv;
    bit          dv;
    bit          ie;
    bit          de;
    logic [31:0] d;
  } exp_t;

  exp_t        q[$];
  logic [31:0] refm [0:1023];
  int          st;
  int          n_vec, n_bad;
  bit          lg_if, lg_dm;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void if_map(input logic [31:0] a, output bit f, output int idx);
    longint off;
    off = longint'(a) - longint'(32'h0040_0000);
    f   = (off < 0) || (a[1:0] != 2'b00) || ((off / 4) >= 512);
    idx = f ? 0 : int'(off / 4);
  endfunction

  function automatic void dm_map(input logic [31:0] a, output bit f, output int idx);
    longint off;
    off = longint'(a) - longint'(32'h1001_0000);
    f   = (off < 0) || (a[1:0] != 2'b00) || (512 + (off / 4) >= 1024);
    idx = f ? 0 : 512 + int'(off / 4);
  endfunction

  // One cycle: at negedge check against the model, then advance the model.
  task automatic step();
    exp_t e, n;
    bit   eg_if, eg_dm, e_en, e_we, fi, fd;
    int   ii, di;
    logic [9:0]  e_addr;
    logic [31:0] e_wd;
    @(negedge clk);
    e = q.pop_front();
    n = '{0, 0, 0, 0, 32'h0};
    eg_if = 0; eg_dm = 0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
    if_map(if_addr, fi, ii);
    dm_map(dm_addr, fd, di);
    if (rst) begin
      e = '{0, 0, 0, 0, 32'h0};
    end else begin
      eg_dm = dm_req && (!if_req || st < 3);
      eg_if = if_req && !eg_dm;
      if (eg_dm) begin
        if (!fd) begin e_en = 1; e_we = dm_we; e_addr = 10'(di); e_wd = dm_wdata; end
        if (dm_we) begin
          n.de = fd;
          if (!fd) refm[di] = dm_wdata;
        end else begin
          n.dv = 1; n.de = fd; n.d = fd ? 32'h0 : refm[di];
        end
      end else if (eg_if) begin
        if (!fi) begin e_en = 1; e_addr = 10'(ii); end
        n.iv = 1; n.ie = fi; n.d = fi ? 32'h0 : refm[ii];
      end
    end
    chk("if_gnt", 64'(if_gnt), 64'(eg_if));
    chk("dm_gnt", 64'(dm_gnt), 64'(eg_dm));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    chk("if_rvalid", 64'(if_rvalid), 64'(e.iv));
    chk("if_rdata", 64'(if_rdata), 64'(e.iv ? e.d : 32'h0));
    chk("if_err", 64'(if_err), 64'(e.ie));
    chk("dm_rvalid", 64'(dm_rvalid), 64'(e.dv));
    chk("dm_rdata", 64'(dm_rdata), 64'(e.dv ? e.d : 32'h0));
    chk("dm_err", 64'(dm_err), 64'(e.de));
    q.push_back(n);
    lg_if = eg_if; lg_dm = eg_dm;
    if (rst || eg_if || !if_req) st = 0;
    else if (st < 3) st++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_if();
    logic [31:0] bad [3];
    bad = '{32'h003F_FFFC, 32'h0040_0001, 32'h0040_0800};
    if ($urandom_range(9) == 0) return bad[$urandom_range(2)];
    return 32'h0040_0000 + 32'($urandom_range(511)) * 4;
  endfunction

  function automatic logic [31:0] rnd_dm();
    logic [31:0] bad [3];
    bad = '{32'h1000_FFFC, 32'h1001_0803, 32'h1001_0800};
    if ($urandom_range(9) == 0) return bad[$urandom_range(2)];
    return 32'h1001_0000 + 32'($urandom_range(511)) * 4;
  endfunction

  initial begin
    logic [7:0] pat;
    for (int i = 0; i < 1024; i++) begin
      phys[i] = {16'h2000 + 16'(i), 16'h0003 + 16'(i)};
      refm[i] = phys[i];
    end
    n_vec = 0; n_bad = 0; st = 0;
    q.push_back('{0, 0, 0, 0, 32'h0});

    // Reset with both requesting: everything held at 0.
    rst = 1; if_req = 1; if_addr = 32'h0040_0000;
    dm_req = 1; dm_we = 0; dm_addr = 32'h1001_0000; dm_wdata = '0;
    step(); step();
    rst = 0;
    step();
    chk("post_rst_dm_first", 64'(lg_dm), 64'd1);
    dm_req = 0; if_req = 0;
    step();

    // Fetch only, word 2.
    if_req = 1; if_addr = 32'h0040_0008;
    step();
    if_req = 0;
    step();

    // Data write then read back at index 513.
    dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF;
    step();
    dm_we = 0; dm_wdata = '0;
    step();
    dm_req = 0;
    step();
    chk("wr_rd_back_phys", 64'(phys[513]), 64'h0000_0000_DEAD_BEEF);

    // Both held for 8 cycles: fetch wins every 4th cycle.
    pat = '0;
    if_req = 1; if_addr = 32'h0040_0010;
    dm_req = 1; dm_addr = 32'h1001_0004;
    for (int i = 0; i < 8; i++) begin
      step();
      pat = {pat[6:0], lg_if};
    end
    chk("starve_pattern", 64'(pat), 64'h11);
    if_req = 0; dm_req = 0;
    step();

    // Faults: misaligned fetch, below-base data read, out-of-range data write.
    if_req = 1; if_addr = 32'h0040_0002;
    dm_req = 1; dm_we = 0; dm_addr = 32'h0FFF_FFFC;
    step();
    dm_req = 0;
    step();
    if_req = 0; dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0802; dm_wdata = 32'h1234_5678;
    step();
    dm_req = 0; dm_we = 0;
    step();

    // Reset right after a read grant discards its response.
    dm_req = 1; dm_addr = 32'h1001_0008;
    step();
    dm_req = 0; rst = 1;
    step();
    rst = 0;
    step();

    // Random traffic; each requester holds its request until granted.
    for (int c = 0; c < 400; c++) begin
      if (lg_if || !if_req) begin
        if_req = ($urandom_range(3) != 0); if_addr = rnd_if();
      end
      if (lg_dm || !dm_req) begin
        dm_req = ($urandom_range(2) != 0); dm_we = ($urandom_range(2) == 0);
        dm_addr = rnd_dm(); dm_wdata = $urandom();
      end
      step();
    end
    if_req = 0; dm_req = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
